// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO register unit: operation codes, FSM states and
// the 64-bit {hi, lo} payload captured from the ALU result register.
package hilo_pkg;

  localparam int unsigned HILO_LATENCY_DEFAULT = 4;
  localparam int unsigned HILO_DATA_W          = 32;
  localparam int unsigned HILO_CNT_W           = 4;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } hilo_op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Upper word goes to HI, lower word to LO
  typedef struct packed {
    logic [HILO_DATA_W-1:0] hi;
    logic [HILO_DATA_W-1:0] lo;
  } hilo_pair_t;

  // Ops that occupy the unit for LATENCY cycles
  function automatic logic is_muldiv(hilo_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_div(hilo_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Every defined op except OP_NONE interlocks against a pending result
  function automatic logic is_interlocked(hilo_op_t op);
    return is_muldiv(op) || (op == MTHI) || (op == MTLO) ||
           (op == MFHI) || (op == MFLO);
  endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register unit. Captures mult/div results from the ALU result register,
// holds them for LATENCY cycles behind a busy interlock, then commits them to
// HI/LO. Also executes MTHI/MTLO and serves MFHI/MFLO reads.
// Optional build macro HILO_FWD_EN: lets MFHI/MFLO issue in the final pending
// cycle, forwarding the value about to be committed.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned LATENCY   = HILO_LATENCY_DEFAULT,  // legal 1..15
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        OpValid,
  input  logic [3:0]  HiLoOp,
  input  logic [63:0] AluResult,
  input  logic [31:0] MoveSrc,
  input  logic        DivisorZero,
  output logic        Stall,
  output logic        Busy,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero
);

  localparam int unsigned CNT_W  = HILO_CNT_W;
  localparam int unsigned DATA_W = HILO_DATA_W;

  hilo_op_t              op;
  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  hilo_pair_t            pend_q;
  logic                  suppress_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rvalid_q;
  logic                  divzero_q;

  logic                  last_cycle;
  logic                  fwd_ok;
  logic                  accept;
  logic                  acc_muldiv;
  logic                  acc_mthi;
  logic                  acc_mtlo;
  logic                  acc_mfhi;
  logic                  acc_mflo;
  logic                  commit;
  logic [DATA_W-1:0]     hi_view;
  logic [DATA_W-1:0]     lo_view;

  assign op = hilo_op_t'(HiLoOp);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter PENDING on an accepted mult/div, leave on the commit edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_muldiv) state_d = PENDING;
      PENDING: if (last_cycle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Interlock, acceptance decode and read-source selection
  always_comb begin
    last_cycle = (state_q == PENDING) && (cnt_q == CNT_W'(1));
    fwd_ok     = 1'b0;
`ifdef HILO_FWD_EN
    fwd_ok     = last_cycle && ((op == MFHI) || (op == MFLO));
`endif
    Stall      = OpValid && (state_q == PENDING) && is_interlocked(op) && !fwd_ok;
    accept     = OpValid && !Stall && (op != OP_NONE);
    acc_muldiv = accept && is_muldiv(op);
    acc_mthi   = accept && (op == MTHI);
    acc_mtlo   = accept && (op == MTLO);
    acc_mfhi   = accept && (op == MFHI);
    acc_mflo   = accept && (op == MFLO);
    commit     = last_cycle && !suppress_q;
    // A forwarded read sees what HI/LO become at this edge
    hi_view    = (fwd_ok && !suppress_q) ? pend_q.hi : hi_q;
    lo_view    = (fwd_ok && !suppress_q) ? pend_q.lo : lo_q;
  end

  // Occupancy counter and captured mult/div payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      pend_q     <= '0;
      suppress_q <= 1'b0;
    end else if (acc_muldiv) begin
      cnt_q      <= CNT_W'(LATENCY);
      pend_q     <= hilo_pair_t'(AluResult);
      suppress_q <= is_div(op) && DivisorZero;
    end else if (state_q == PENDING) begin
      cnt_q      <= cnt_q - CNT_W'(1);
    end
  end

  // Architectural HI/LO: commit of a pending result or a direct move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= RESET_VAL;
      lo_q <= RESET_VAL;
    end else begin
      if (commit) begin
        hi_q <= pend_q.hi;
        lo_q <= pend_q.lo;
      end
      if (acc_mthi) hi_q <= MoveSrc;
      if (acc_mtlo) lo_q <= MoveSrc;
    end
  end

  // MFHI/MFLO read port with one-cycle valid pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= acc_mfhi || acc_mflo;
      if (acc_mfhi)      rdata_q <= hi_view;
      else if (acc_mflo) rdata_q <= lo_view;
    end
  end

  // Sticky divide-by-zero flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divzero_q <= 1'b0;
    end else if (acc_muldiv && is_div(op) && DivisorZero) begin
      divzero_q <= 1'b1;
    end
  end

  assign Busy      = (state_q == PENDING);
  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivZero   = divzero_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: two instances (LATENCY 4 and 1) share one stimulus
// stream; a commit-time model checks every output each cycle, plus directed
// scenarios with literal expectations.
`timescale 1ns/1ps
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        OpValid = 1'b0;
  logic [3:0]  HiLoOp = 4'd0;
  logic [63:0] AluResult = 64'd0;
  logic [31:0] MoveSrc = 32'd0;
  logic        DivisorZero = 1'b0;

  logic        stall [2];
  logic        busy  [2];
  logic [31:0] rd    [2];
  logic        rv    [2];
  logic [31:0] hi    [2];
  logic [31:0] lo    [2];
  logic        dz    [2];

  int unsigned lat_of [2] = '{4, 1};
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hilo_unit #(.LATENCY(4), .RESET_VAL(32'h0)) u_lat4 (
    .clk(clk), .reset(reset), .OpValid(OpValid), .HiLoOp(HiLoOp),
    .AluResult(AluResult), .MoveSrc(MoveSrc), .DivisorZero(DivisorZero),
    .Stall(stall[0]), .Busy(busy[0]), .ReadData(rd[0]), .ReadValid(rv[0]),
    .Hi(hi[0]), .Lo(lo[0]), .DivZero(dz[0]));

  hilo_unit #(.LATENCY(1), .RESET_VAL(32'h0)) u_lat1 (
    .clk(clk), .reset(reset), .OpValid(OpValid), .HiLoOp(HiLoOp),
    .AluResult(AluResult), .MoveSrc(MoveSrc), .DivisorZero(DivisorZero),
    .Stall(stall[1]), .Busy(busy[1]), .ReadData(rd[1]), .ReadValid(rv[1]),
    .Hi(hi[1]), .Lo(lo[1]), .DivZero(dz[1]));

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A mult/div accepted at edge e commits at edge e+LATENCY; the unit is busy
  // while a commit is outstanding.
  int unsigned edge_n = 0;
  logic [31:0] m_hi [2], m_lo [2], m_rd [2], m_phi [2], m_plo [2];
  logic        m_rv [2], m_dz [2], m_pend [2], m_sup [2];
  int unsigned m_commit [2];

  function automatic bit m_stall(input int i, input int unsigned e);
    bit listed;
    bit fwd;
    listed = (HiLoOp >= 4'd1) && (HiLoOp <= 4'd8);
    fwd    = 1'b0;
`ifdef HILO_FWD_EN
    fwd    = ((HiLoOp == 4'(MFHI)) || (HiLoOp == 4'(MFLO))) && (e == m_commit[i]);
`endif
    return OpValid && m_pend[i] && listed && !fwd;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_hi[i] <= 32'h0; m_lo[i] <= 32'h0; m_rd[i] <= 32'h0;
        m_rv[i] <= 1'b0;  m_dz[i] <= 1'b0;  m_pend[i] <= 1'b0;
        m_sup[i] <= 1'b0; m_phi[i] <= 32'h0; m_plo[i] <= 32'h0;
        m_commit[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] h, l, r;
        logic        v, z, p, s;
        logic [31:0] ph, pl;
        int unsigned c;
        bit          acc;
        int unsigned e;
        e   = edge_n + 1;
        h = m_hi[i]; l = m_lo[i]; r = m_rd[i]; z = m_dz[i];
        p = m_pend[i]; s = m_sup[i]; ph = m_phi[i]; pl = m_plo[i]; c = m_commit[i];
        v   = 1'b0;
        acc = OpValid && !m_stall(i, e) && (HiLoOp != 4'd0);
        if (p && e == c) begin
          if (!s) begin h = ph; l = pl; end
          p = 1'b0;
        end
        if (acc) begin
          case (HiLoOp)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              p  = 1'b1;
              c  = e + lat_of[i];
              ph = AluResult[63:32];
              pl = AluResult[31:0];
              s  = (HiLoOp == 4'd3 || HiLoOp == 4'd4) && DivisorZero;
              if (s) z = 1'b1;
            end
            4'd5: h = MoveSrc;
            4'd6: l = MoveSrc;
            4'd7: begin r = h; v = 1'b1; end
            4'd8: begin r = l; v = 1'b1; end
            default: ;
          endcase
        end
        m_hi[i] <= h; m_lo[i] <= l; m_rd[i] <= r; m_rv[i] <= v; m_dz[i] <= z;
        m_pend[i] <= p; m_sup[i] <= s; m_phi[i] <= ph; m_plo[i] <= pl;
        m_commit[i] <= c;
      end
      edge_n <= edge_n + 1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("stall", i, 64'(stall[i]), 64'(m_stall(i, edge_n + 1)));
      chk("busy",  i, 64'(busy[i]),  64'(m_pend[i]));
      chk("hi",    i, 64'(hi[i]),    64'(m_hi[i]));
      chk("lo",    i, 64'(lo[i]),    64'(m_lo[i]));
      chk("rvalid",i, 64'(rv[i]),    64'(m_rv[i]));
      chk("rdata", i, 64'(rd[i]),    64'(m_rd[i]));
      chk("divzero", i, 64'(dz[i]),  64'(m_dz[i]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    OpValid = 1'b0; HiLoOp = 4'd0; DivisorZero = 1'b0;
  endtask

  // Present an op and hold it until instance idx accepts it
  task automatic issue(input logic [3:0] op, input logic [63:0] alu,
                       input logic [31:0] mv, input logic dzin,
                       input int idx, output int stalls);
    OpValid = 1'b1; HiLoOp = op; AluResult = alu; MoveSrc = mv; DivisorZero = dzin;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall[idx]) break;
      stalls++;
    end
    if (stalls >= 40) chk("issue_timeout", idx, 64'(stalls), 64'd0);
    tick();
    idle_in();
  endtask

  // Count cycles with Busy high, starting now
  task automatic count_busy(input int idx, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy[idx]) break;
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!busy[0] && !busy[1]) break;
      tick();
    end
    if (k >= 40) chk("idle_timeout", 0, 64'(k), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int nb;
    int exp_fwd_stalls;
`ifdef HILO_FWD_EN
    exp_fwd_stalls = 3;
`else
    exp_fwd_stalls = 4;
`endif
    reset = 1'b1;
    idle_in();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_hi",  0, 64'(hi[0]),  64'h0);
    chk("rst_lo",  0, 64'(lo[0]),  64'h0);
    chk("rst_busy",0, 64'(busy[0]),64'h0);
    chk("rst_dz",  0, 64'(dz[0]),  64'h0);
    chk("rst_rv",  0, 64'(rv[0]),  64'h0);

    // MFHI after reset
    issue(4'(MFHI), 64'h0, 32'h0, 1'b0, 0, s);
    chk("mfhi_rd", 0, 64'(rd[0]), 64'h0);
    chk("mfhi_rv", 0, 64'(rv[0]), 64'h1);
    tick();
    chk("mfhi_rv_pulse", 0, 64'(rv[0]), 64'h0);

    // MULT latency and commit
    issue(4'(MULT), 64'h0000_0001_FFFF_FFFE, 32'h0, 1'b0, 0, s);
    count_busy(0, nb);
    chk("mult_busy_cycles", 0, 64'(nb), 64'd4);
    chk("mult_hi", 0, 64'(hi[0]), 64'h1);
    chk("mult_lo", 0, 64'(lo[0]), 64'hFFFF_FFFE);
    wait_idle();

    // MULT then MFLO: interlock length and read data
    issue(4'(MULT), 64'hAAAA_0000_5555_1234, 32'h0, 1'b0, 0, s);
    issue(4'(MFLO), 64'h0, 32'h0, 1'b0, 0, s);
    chk("mflo_stalls", 0, 64'(s), 64'(exp_fwd_stalls));
    chk("mflo_rd", 0, 64'(rd[0]), 64'h5555_1234);
    chk("mflo_rv", 0, 64'(rv[0]), 64'h1);
    wait_idle();

    // MTHI / MTLO
    issue(4'(MTHI), 64'h0, 32'hDEAD_BEEF, 1'b0, 0, s);
    chk("mthi_hi", 0, 64'(hi[0]), 64'hDEAD_BEEF);
    issue(4'(MTLO), 64'h0, 32'h0000_1234, 1'b0, 0, s);
    chk("mtlo_lo", 0, 64'(lo[0]), 64'h1234);
    chk("mtlo_hi_kept", 0, 64'(hi[0]), 64'hDEAD_BEEF);

    // Divide by zero keeps HI/LO and sets the sticky flag
    issue(4'(MTHI), 64'h0, 32'd5, 1'b0, 0, s);
    issue(4'(MTLO), 64'h0, 32'd6, 1'b0, 0, s);
    issue(4'(DIV), 64'h1234_5678_9ABC_DEF0, 32'h0, 1'b1, 0, s);
    chk("div0_flag", 0, 64'(dz[0]), 64'h1);
    count_busy(0, nb);
    chk("div0_busy_cycles", 0, 64'(nb), 64'd4);
    chk("div0_hi", 0, 64'(hi[0]), 64'd5);
    chk("div0_lo", 0, 64'(lo[0]), 64'd6);
    chk("div0_sticky", 0, 64'(dz[0]), 64'h1);
    wait_idle();

    // LATENCY=1 instance: DIVU then MULTU back to back
    issue(4'(DIVU), 64'h0000_0007_0000_0003, 32'h0, 1'b0, 1, s);
    issue(4'(MULTU), 64'h0000_0002_0000_0010, 32'h0, 1'b0, 1, s);
    chk("b2b_stalls", 1, 64'(s), 64'd1);
    chk("b2b_divu_hi", 1, 64'(hi[1]), 64'd7);
    chk("b2b_divu_lo", 1, 64'(lo[1]), 64'd3);
    chk("b2b_busy", 1, 64'(busy[1]), 64'h1);
    tick();
    chk("b2b_multu_hi", 1, 64'(hi[1]), 64'd2);
    chk("b2b_multu_lo", 1, 64'(lo[1]), 64'h10);
    wait_idle();

    // Reset during PENDING discards the result
    issue(4'(MULT), 64'hFFFF_0000_EEEE_0000, 32'h0, 1'b0, 0, s);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 0, 64'(busy[0]), 64'h0);
    chk("midrst_hi", 0, 64'(hi[0]), 64'h0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("midrst_no_commit_hi", 0, 64'(hi[0]), 64'h0);
    chk("midrst_no_commit_lo", 0, 64'(lo[0]), 64'h0);
    chk("midrst_idle", 0, 64'(busy[0]), 64'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 249) == 0);
      OpValid     = ($urandom_range(0, 3) != 0);
      HiLoOp      = 4'($urandom_range(0, 10));
      AluResult   = {$urandom, $urandom};
      MoveSrc     = $urandom;
      DivisorZero = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0;
    idle_in();
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
